// File: rtl/length_acc_pkg.sv
// Shared types and width helpers for the compressed-length accumulator.
package length_acc_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    PAD,
    EMIT
  } acc_state_e;

  localparam int unsigned DEF_WORD_SIZE = 64;
  localparam int unsigned PART_W        = $clog2(DEF_WORD_SIZE) + 1;
  localparam int unsigned FILL_W        = PART_W;

  // Partial-word counter width: must hold WORD_SIZE itself (a full pad).
  function automatic int unsigned part_width(input int unsigned word_size);
    return $clog2(word_size) + 1;
  endfunction

endpackage

// File: rtl/word_boundary_calc.sv
// Combinational word-boundary arithmetic: new partial count, store/spill and remainder.
module word_boundary_calc
  import length_acc_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned LEN_W     = 7,
  parameter int unsigned PartW     = part_width(WORD_SIZE),
  parameter int unsigned SpillW    = $clog2(WORD_SIZE)
) (
  input  logic [PartW-1:0]  i_partial,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_store,
  output logic [SpillW-1:0] o_spill,
  output logic [PartW-1:0]  o_remainder
);

  localparam int unsigned NpW = PartW + 1;

  logic [NpW-1:0] w_np;

  assign w_np        = NpW'(i_partial) + NpW'(i_len);
  assign o_store     = (w_np >= NpW'(WORD_SIZE));
  assign o_spill     = o_store ? SpillW'(w_np - NpW'(WORD_SIZE)) : '0;
  assign o_remainder = o_store ? PartW'(w_np - NpW'(WORD_SIZE)) : PartW'(w_np);

endmodule

// File: rtl/length_accumulator_hs.sv
// Per-word / per-line compressed-length accumulator with handshakes, end-of-line
// padding and sticky overflow (raw-line fallback).
module length_accumulator_hs
  import length_acc_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 64,
  parameter int unsigned CACHE_LINE = 128,
  parameter int unsigned LEN_W      = 7,
  parameter int unsigned CNT_W      = $clog2(CACHE_LINE) + 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_len_valid,
  output logic                         o_len_ready,
  input  logic [LEN_W-1:0]             i_len,
  input  logic                         i_last,
  output logic [CNT_W-1:0]             o_shift_amount,
  output logic                         o_store_flag,
  output logic [$clog2(WORD_SIZE)-1:0] o_spill,
  output logic                         o_fill_flag,
  output logic [$clog2(WORD_SIZE):0]   o_fill_bits,
  output logic                         o_line_valid,
  input  logic                         i_line_ready,
  output logic [CNT_W-1:0]             o_line_bits,
  output logic                         o_overflow
);

  localparam int unsigned PartW  = part_width(WORD_SIZE);
  localparam int unsigned SpillW = $clog2(WORD_SIZE);
  localparam int unsigned FillW  = PartW;

  // A single length must be able to express a whole word, but never two,
  // so one accept crosses at most one word boundary.
  if (2 ** (LEN_W - 1) > WORD_SIZE) begin : g_len_w_chk
    $error("LEN_W too wide for WORD_SIZE");
  end
  if (CACHE_LINE % WORD_SIZE != 0) begin : g_line_chk
    $error("CACHE_LINE must be a multiple of WORD_SIZE");
  end

  acc_state_e       r_state, w_state_next;
  logic [PartW-1:0] r_partial, w_partial_next;
  logic [CNT_W-1:0] r_total, w_total_next;
  logic             r_ovf, w_ovf_next;

  logic              w_store;
  logic [SpillW-1:0] w_spill;
  logic [PartW-1:0]  w_remainder;
  logic              w_accept;
  logic [CNT_W:0]    w_nt_wide;
  logic [CNT_W-1:0]  w_nt;
  logic              w_nt_ovf;
  logic [FillW-1:0]  w_fill_bits;

  word_boundary_calc #(
    .WORD_SIZE(WORD_SIZE),
    .LEN_W    (LEN_W),
    .PartW    (PartW),
    .SpillW   (SpillW)
  ) u_wbc (
    .i_partial  (r_partial),
    .i_len      (i_len),
    .o_store    (w_store),
    .o_spill    (w_spill),
    .o_remainder(w_remainder)
  );

  assign w_nt_wide   = {1'b0, r_total} + (CNT_W + 1)'(i_len);
  assign w_nt        = w_nt_wide[CNT_W] ? '1 : w_nt_wide[CNT_W-1:0];
  assign w_nt_ovf    = (w_nt > CNT_W'(CACHE_LINE));
  assign w_fill_bits = FillW'(WORD_SIZE) - r_partial;
  assign w_accept    = i_len_valid & (r_state == ACCUM) & ~i_reset;

  always_comb begin
    w_state_next   = r_state;
    w_partial_next = r_partial;
    w_total_next   = r_total;
    w_ovf_next     = r_ovf;
    o_len_ready    = 1'b0;
    o_store_flag   = 1'b0;
    o_spill        = '0;
    o_fill_flag    = 1'b0;
    o_fill_bits    = '0;
    o_line_valid   = 1'b0;
    o_line_bits    = '0;
    o_overflow     = 1'b0;
    o_shift_amount = r_total;

    unique case (r_state)
      ACCUM: begin
        o_len_ready = 1'b1;
        if (w_accept) begin
          o_store_flag   = w_store;
          o_spill        = w_spill;
          w_partial_next = w_remainder;
          w_total_next   = w_nt;
          w_ovf_next     = r_ovf | w_nt_ovf;
          if (i_last) begin
            w_state_next = ((w_remainder != '0) && !w_ovf_next) ? PAD : EMIT;
          end
        end
      end
      PAD: begin
        o_fill_flag    = 1'b1;
        o_fill_bits    = w_fill_bits;
        o_store_flag   = 1'b1;
        w_total_next   = r_total + CNT_W'(w_fill_bits);
        w_partial_next = '0;
        w_state_next   = EMIT;
      end
      EMIT: begin
        o_line_valid = 1'b1;
        o_line_bits  = r_ovf ? CNT_W'(CACHE_LINE) : r_total;
        o_overflow   = r_ovf;
        if (i_line_ready) begin
          w_total_next   = '0;
          w_partial_next = '0;
          w_ovf_next     = 1'b0;
          w_state_next   = ACCUM;
        end
      end
      default: w_state_next = ACCUM;
    endcase

    // Reset silences every output, including the ready.
    if (i_reset) begin
      o_len_ready    = 1'b0;
      o_store_flag   = 1'b0;
      o_spill        = '0;
      o_fill_flag    = 1'b0;
      o_fill_bits    = '0;
      o_line_valid   = 1'b0;
      o_line_bits    = '0;
      o_overflow     = 1'b0;
      o_shift_amount = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ACCUM;
      r_partial <= '0;
      r_total   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_partial <= w_partial_next;
      r_total   <= w_total_next;
      r_ovf     <= w_ovf_next;
    end
  end

endmodule

// File: tb/tb_length_accumulator_hs.sv
// Directed table-driven bench for length_accumulator_hs (WORD_SIZE=64, CACHE_LINE=128).
module tb_length_accumulator_hs;

  logic       clk = 1'b0;
  logic       rst;
  logic       len_valid;
  logic       len_ready;
  logic [6:0] len;
  logic       last;
  logic [8:0] shift_amount;
  logic       store_flag;
  logic [5:0] spill;
  logic       fill_flag;
  logic [6:0] fill_bits;
  logic       line_valid;
  logic       line_ready;
  logic [8:0] line_bits;
  logic       overflow;

  always #5 clk = ~clk;

  length_accumulator_hs #(
    .WORD_SIZE (64),
    .CACHE_LINE(128),
    .LEN_W     (7),
    .CNT_W     (9)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_len_valid   (len_valid),
    .o_len_ready   (len_ready),
    .i_len         (len),
    .i_last        (last),
    .o_shift_amount(shift_amount),
    .o_store_flag  (store_flag),
    .o_spill       (spill),
    .o_fill_flag   (fill_flag),
    .o_fill_bits   (fill_bits),
    .o_line_valid  (line_valid),
    .i_line_ready  (line_ready),
    .o_line_bits   (line_bits),
    .o_overflow    (overflow)
  );

  typedef struct {
    int rst, v, len, last, lr;
    int rdy, sh, st, sp, ff, fb, lv, lb, ov;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(int rst_, int v, int len_, int last_, int lr,
                              int rdy, int sh, int st, int sp, int ff, int fb,
                              int lv, int lb, int ov);
    vec_t r;
    r.rst = rst_; r.v = v; r.len = len_; r.last = last_; r.lr = lr;
    r.rdy = rdy; r.sh = sh; r.st = st; r.sp = sp; r.ff = ff; r.fb = fb;
    r.lv = lv; r.lb = lb; r.ov = ov;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    if (act != exp) begin
      n_miss++;
      $display("FAIL vec %0d %s: got %0d expected %0d", n_vec, nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst        = v.rst[0];
    len_valid  = v.v[0];
    len        = 7'(v.len);
    last       = v.last[0];
    line_ready = v.lr[0];
  endtask

  task automatic apply(input vec_t v);
    drive(v);
    #1;
    chk("len_ready", int'(len_ready), v.rdy);
    chk("shift_amount", int'(shift_amount), v.sh);
    chk("store_flag", int'(store_flag), v.st);
    chk("spill", int'(spill), v.sp);
    chk("fill_flag", int'(fill_flag), v.ff);
    chk("fill_bits", int'(fill_bits), v.fb);
    chk("line_valid", int'(line_valid), v.lv);
    chk("line_bits", int'(line_bits), v.lb);
    chk("overflow", int'(overflow), v.ov);
    n_vec++;
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit seen;
    //             rst v len lst lr  rdy sh  st sp ff fb lv lb  ov
    vecs.push_back(mk(1, 1, 40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // 30,30,4: exact fill, no pad; close the line with a zero-length last
    vecs.push_back(mk(0, 1, 30, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 30, 0, 0, 1, 30, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0, 1, 60, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 64, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 64, 0, 0, 0, 0, 1, 64, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // 40,40 last: store+spill, then pad of 48
    vecs.push_back(mk(0, 1, 40, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 40, 1, 0, 1, 40, 1, 16, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 80, 1, 0, 1, 48, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 128, 0, 0, 0, 0, 1, 128, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // 60,60,20 last: overflow, pad skipped, EMIT stalled 5 cycles
    vecs.push_back(mk(0, 1, 60, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 60, 0, 0, 1, 60, 1, 56, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 20, 1, 0, 1, 120, 1, 12, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1, 33, 0, 0, 0, 140, 0, 0, 0, 0, 1, 128, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 140, 0, 0, 0, 0, 1, 128, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // single zero-length last word
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // reset while in EMIT discards the line, then a clean 64-bit line
    vecs.push_back(mk(0, 1, 64, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 64, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 64, 0, 0, 0, 0, 1, 64, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (vecs[i]) apply(vecs[i]);

    // Reset during PAD: 40 + 10 (last) leaves 50 bits, so the next cycle is PAD.
    apply(mk(0, 1, 40, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 1, 10, 1, 0, 1, 40, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 1, 64, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));

    // Bounded wait for the line summary of the post-reset 64-bit line.
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      drive(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      n_vec++;
      if (line_valid) begin
        seen = 1'b1;
        chk("post_reset_line_bits", int'(line_bits), 64);
        chk("post_reset_overflow", int'(overflow), 0);
      end
      @(posedge clk);
      #2;
    end
    if (!seen) begin
      n_miss++;
      $display("FAIL post_reset_line_valid: got 0 expected 1 within 4 cycles");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
